shift_seq_ctrl: RTL and testbench

//  Sequencer for the serial shift datapath.
//  - Accepts a parallel word on a valid/ready handshake.
//  - Loads the word into an internal parallel-in/serial-out shift register.
//  - Shifts the word out one bit per enabled cycle, with a per-bit valid and an end-of-word pulse.
//  - Inserts a programmable idle gap between words.
//  - Sits between a word producer and a serial sink (SISO chain, serial link).

---
 rtl/shift_seq_ctrl_pkg.sv | 16 +
 rtl/piso_sreg.sv | 51 +++++
 rtl/shift_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the serial shift sequencer: FSM encodings and
// the legal ranges of the word width and inter-word gap.
package shift_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    localparam int GAP_MAX   = 15;
    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/piso_sreg.sv
// Parallel-in / serial-out shift register. A load takes priority over a
// shift; shifting moves data toward the output tap and fills with zero.
module piso_sreg #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] pdin,
    output logic             sout
);

    logic [WIDTH-1:0] sreg_reg;
    logic [WIDTH-1:0] sreg_shifted;

    // Per-bit shifted value: each bit takes its neighbour on the far side
    // of the tap; the bit furthest from the tap is filled with zero.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (LSB_FIRST) begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign sreg_shifted[gi] = 1'b0;
                end else begin : g_move
                    assign sreg_shifted[gi] = sreg_reg[gi+1];
                end
            end else begin : g_msb
                if (gi == 0) begin : g_fill
                    assign sreg_shifted[gi] = 1'b0;
                end else begin : g_move
                    assign sreg_shifted[gi] = sreg_reg[gi-1];
                end
            end
        end
    endgenerate

    assign sout = LSB_FIRST ? sreg_reg[0] : sreg_reg[WIDTH-1];

    // Shift register state: reset clears, load captures, shift advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_reg <= '0;
        end else if (load) begin
            sreg_reg <= pdin;
        end else if (shift) begin
            sreg_reg <= sreg_shifted;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serial shift sequencer: accepts a word on a valid/ready handshake,
// shifts it out one bit per unheld cycle, then idles for GAP cycles.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int GAP       = 1,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             hold,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
    // Terminal gap count; only meaningful when GAP > 0.
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

    state_t               state_reg,   state_next;
    logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [GAP_CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic                 sreg_load;
    logic                 sreg_shift;
    logic                 sreg_tap;

    piso_sreg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_sreg (
        .clk   (clk),
        .reset (reset),
        .load  (sreg_load),
        .shift (sreg_shift),
        .pdin  (din),
        .sout  (sreg_tap)
    );

    // The tap is only presented while shifting; elsewhere the line is quiet.
    assign sout = (state_reg == ST_SHIFT) && sreg_tap;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    // Next-state, counter updates and handshake/strobe outputs.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        sreg_load    = 1'b0;
        sreg_shift   = 1'b0;
        din_ready    = 1'b0;
        sout_valid   = 1'b0;
        done         = 1'b0;
        busy         = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                din_ready = 1'b1;
                busy      = 1'b0;
                if (din_valid) begin
                    sreg_load    = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                sout_valid = !hold;
                if (!hold) begin
                    sreg_shift = 1'b1;
                    if (bit_cnt_reg == LAST_BIT) begin
                        done = 1'b1;
                        if (GAP > 0) begin
                            gap_cnt_next = '0;
                            state_next   = ST_GAP;
                        end else begin
                            state_next   = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (!hold) begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_next = ST_IDLE;
                    end else begin
                        gap_cnt_next = gap_cnt_reg + 1'b1;
                    end
                end
            end

            // Unused encoding: fall back to IDLE on the next edge.
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: three instances cover LSB-first with
// a one-cycle gap, MSB-first, and an 8-bit word with no gap.
module tb_shift_seq_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // Instance A: WIDTH=4, GAP=1, LSB first
    logic [3:0] din_a;
    logic       dv_a, hold_a;
    logic       rdy_a, sout_a, sv_a, busy_a, done_a;
    // Instance B: WIDTH=4, GAP=1, MSB first
    logic [3:0] din_b;
    logic       dv_b, hold_b;
    logic       rdy_b, sout_b, sv_b, busy_b, done_b;
    // Instance C: WIDTH=8, GAP=0, LSB first
    logic [7:0] din_c;
    logic       dv_c, hold_c;
    logic       rdy_c, sout_c, sv_c, busy_c, done_c;

    int vec_cnt = 0;
    int err_cnt = 0;

    shift_seq_ctrl #(.WIDTH(4), .GAP(1), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .din(din_a), .din_valid(dv_a), .din_ready(rdy_a),
        .hold(hold_a), .sout(sout_a), .sout_valid(sv_a), .busy(busy_a), .done(done_a)
    );

    shift_seq_ctrl #(.WIDTH(4), .GAP(1), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .din(din_b), .din_valid(dv_b), .din_ready(rdy_b),
        .hold(hold_b), .sout(sout_b), .sout_valid(sv_b), .busy(busy_b), .done(done_b)
    );

    shift_seq_ctrl #(.WIDTH(8), .GAP(0), .LSB_FIRST(1'b1)) dut_c (
        .clk(clk), .reset(reset), .din(din_c), .din_valid(dv_c), .din_ready(rdy_c),
        .hold(hold_c), .sout(sout_c), .sout_valid(sv_c), .busy(busy_c), .done(done_c)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s : got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("vec %s : %0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [10:0] e_rdy, e_sv, e_so, e_dn;
    logic [7:0]  s_so, s_sv, s_dn;
    logic [3:0]  b_so;
    logic [7:0]  c_so;

    initial begin
        reset = 1'b1;
        din_a = '0; dv_a = 1'b0; hold_a = 1'b0;
        din_b = '0; dv_b = 1'b0; hold_b = 1'b0;
        din_c = '0; dv_c = 1'b0; hold_c = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        check_vec("rst_rdy",  32'(rdy_a),  1);
        check_vec("rst_busy", 32'(busy_a), 0);
        check_vec("rst_sout", 32'(sout_a), 0);
        check_vec("rst_sv",   32'(sv_a),   0);
        check_vec("rst_done", 32'(done_a), 0);

        // 1. Basic word 1011, LSB first -> 1,1,0,1
        din_a = 4'b1011; dv_a = 1'b1;
        #1 check_vec("t1_hs_rdy", 32'(rdy_a), 1);
        tick();
        dv_a = 1'b0; din_a = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            b_so = 4'b1011;
            check_vec($sformatf("t1_sout%0d", i), 32'(sout_a), 32'(b_so[i]));
            check_vec($sformatf("t1_sv%0d", i),   32'(sv_a),   1);
            check_vec($sformatf("t1_done%0d", i), 32'(done_a), (i == 3) ? 1 : 0);
            check_vec($sformatf("t1_rdy%0d", i),  32'(rdy_a),  0);
            tick();
        end
        #1;
        check_vec("t1_gap_rdy",  32'(rdy_a),  0);
        check_vec("t1_gap_busy", 32'(busy_a), 1);
        check_vec("t1_gap_sv",   32'(sv_a),   0);
        tick();
        check_vec("t1_idle_rdy", 32'(rdy_a), 1);

        // 2. MSB first, 1011 -> 1,0,1,1
        din_b = 4'b1011; dv_b = 1'b1;
        tick();
        dv_b = 1'b0;
        b_so = 4'b1101;   // index i = i-th bit on the wire
        for (int i = 0; i < 4; i++) begin
            #1;
            check_vec($sformatf("t2_sout%0d", i), 32'(sout_b), 32'(b_so[i]));
            check_vec($sformatf("t2_done%0d", i), 32'(done_b), (i == 3) ? 1 : 0);
            tick();
        end
        tick();

        // 2b. MSB first, 0001 -> 0,0,0,1 with hold on the last bit
        din_b = 4'b0001; dv_b = 1'b1;
        tick();
        dv_b = 1'b0;
        tick(); tick(); tick();
        hold_b = 1'b1;
        #1;
        check_vec("t2b_hold_sout", 32'(sout_b), 1);
        check_vec("t2b_hold_sv",   32'(sv_b),   0);
        check_vec("t2b_hold_done", 32'(done_b), 0);
        tick();
        hold_b = 1'b0;
        #1;
        check_vec("t2b_rel_sout", 32'(sout_b), 1);
        check_vec("t2b_rel_sv",   32'(sv_b),   1);
        check_vec("t2b_rel_done", 32'(done_b), 1);
        tick();
        tick();

        // 3. Stall: 0110 -> 0,1,1,0 with hold on the 2nd bit for 3 cycles
        din_a = 4'b0110; dv_a = 1'b1;
        tick();
        dv_a = 1'b0;
        s_so = 8'b0111_1100;
        s_sv = 8'b1110_0010;
        s_dn = 8'b1000_0000;
        for (int c = 1; c <= 7; c++) begin
            hold_a = (c >= 2 && c <= 4);
            #1;
            check_vec($sformatf("t3_sout_c%0d", c), 32'(sout_a), 32'(s_so[c]));
            check_vec($sformatf("t3_sv_c%0d", c),   32'(sv_a),   32'(s_sv[c]));
            check_vec($sformatf("t3_done_c%0d", c), 32'(done_a), 32'(s_dn[c]));
            tick();
        end
        // Hold also freezes the gap
        hold_a = 1'b1;
        #1 check_vec("t3_gap_held_rdy", 32'(rdy_a), 0);
        tick();
        hold_a = 1'b0;
        #1 check_vec("t3_gap_rel_rdy", 32'(rdy_a), 0);
        tick();
        check_vec("t3_idle_rdy", 32'(rdy_a), 1);

        // 4. Back-to-back: A then 5 with din_valid held high
        e_rdy = 11'b00001000001;
        e_sv  = 11'b11110011110;
        e_so  = 11'b01010010100;
        e_dn  = 11'b10000010000;
        din_a = 4'hA; dv_a = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c >= 1) din_a = 4'h5;
            if (c >= 7) dv_a = 1'b0;
            #1;
            check_vec($sformatf("t4_rdy_c%0d", c),  32'(rdy_a),  32'(e_rdy[c]));
            check_vec($sformatf("t4_sv_c%0d", c),   32'(sv_a),   32'(e_sv[c]));
            check_vec($sformatf("t4_sout_c%0d", c), 32'(sout_a), 32'(e_so[c]));
            check_vec($sformatf("t4_done_c%0d", c), 32'(done_a), 32'(e_dn[c]));
            tick();
        end
        tick();
        check_vec("t4_idle_rdy", 32'(rdy_a), 1);

        // 5. Reset during the 3rd bit
        din_a = 4'b1111; dv_a = 1'b1;
        tick();
        dv_a = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_vec("t5_rdy",  32'(rdy_a),  1);
        check_vec("t5_busy", 32'(busy_a), 0);
        check_vec("t5_sout", 32'(sout_a), 0);
        check_vec("t5_sv",   32'(sv_a),   0);
        check_vec("t5_done", 32'(done_a), 0);
        tick();
        check_vec("t5_after_sv", 32'(sv_a), 0);

        // 6. WIDTH=8, GAP=0, 0x81 -> 1,0,0,0,0,0,0,1 then straight to IDLE
        din_c = 8'h81; dv_c = 1'b1;
        tick();
        dv_c = 1'b0;
        c_so = 8'b1000_0001;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_vec($sformatf("t6_sout%0d", i), 32'(sout_c), 32'(c_so[i]));
            check_vec($sformatf("t6_sv%0d", i),   32'(sv_c),   1);
            check_vec($sformatf("t6_done%0d", i), 32'(done_c), (i == 7) ? 1 : 0);
            tick();
        end
        #1;
        check_vec("t6_idle_rdy",  32'(rdy_c),  1);
        check_vec("t6_idle_busy", 32'(busy_c), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
